// File: rtl/sprite_pixel_fetch.sv
// Spritesheet pixel fetch: turns a sprite-relative request into a linear ROM
// read, realigns the colour index with its sideband after the fixed ROM
// latency, and counts opaque pixels per frame.
module sprite_pixel_fetch #(
    parameter int unsigned SHEET_W = 256,
    parameter int unsigned SHEET_H = 256,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned CIDX_W  = 3,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    input  logic [9:0]        spritesheet_x,
    input  logic [9:0]        spritesheet_y,
    input  logic [9:0]        spritesheet_xoffset,
    input  logic [9:0]        spritesheet_yoffset,
    input  logic              chef_in,
    input  logic [9:0]        drawx_in,
    input  logic [9:0]        drawy_in,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [CIDX_W-1:0] rom_data,
    output logic              pix_valid,
    output logic [CIDX_W-1:0] sprite_color_index,
    output logic [9:0]        pix_drawx,
    output logic [9:0]        pix_drawy,
    output logic              pix_chef,
    output logic              pix_transparent,
    output logic              pix_oob,
    output logic [15:0]       opaque_count
);

    localparam int unsigned SUM_W = 11;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LIN_W = 32;

    typedef struct packed {
        logic       valid;
        logic       oob;
        logic       chef;
        logic [9:0] drawx;
        logic [9:0] drawy;
    } sideband_t;

    logic [SUM_W-1:0]  px_c;
    logic [SUM_W-1:0]  py_c;
    logic [LIN_W-1:0]  lin_c;
    logic              oob_c;
    logic              rd_c;

    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              rom_rd_d, rom_rd_q;
    sideband_t         sb_d [0:ROM_LAT];
    sideband_t         sb_q [0:ROM_LAT];
    sideband_t         sb_last_c;

    logic              pix_valid_d, pix_valid_q;
    logic [CIDX_W-1:0] cidx_d, cidx_q;
    logic [9:0]        drawx_d, drawx_q;
    logic [9:0]        drawy_d, drawy_q;
    logic              chef_d, chef_q;
    logic              transp_d, transp_q;
    logic              oob_d, oob_q;
    logic [CNT_W-1:0]  count_d, count_q;

    // Stage A: sheet coordinates, bounds test and linear address
    always_comb begin
        px_c  = SUM_W'(spritesheet_x) + SUM_W'(spritesheet_xoffset);
        py_c  = SUM_W'(spritesheet_y) + SUM_W'(spritesheet_yoffset);
        oob_c = (LIN_W'(px_c) >= SHEET_W) || (LIN_W'(py_c) >= SHEET_H);
        lin_c = LIN_W'(py_c) * SHEET_W + LIN_W'(px_c);
        rd_c  = req_valid && !oob_c;
    end

    // ROM request and sideband delay line; address holds when no read issues
    always_comb begin
        rom_rd_d   = rd_c;
        rom_addr_d = rom_addr_q;
        if (rd_c) begin
            rom_addr_d = lin_c[ADDR_W-1:0];
        end
        sb_d[0].valid = req_valid;
        sb_d[0].oob   = req_valid && oob_c;
        sb_d[0].chef  = chef_in;
        sb_d[0].drawx = drawx_in;
        sb_d[0].drawy = drawy_in;
        for (int i = 1; i <= int'(ROM_LAT); i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // Output stage: merge ROM data with the aligned sideband
    always_comb begin
        sb_last_c   = sb_q[ROM_LAT];
        pix_valid_d = sb_last_c.valid;
        cidx_d      = '0;
        if (sb_last_c.valid && !sb_last_c.oob) begin
            cidx_d = rom_data;
        end
        transp_d = sb_last_c.valid && (cidx_d == '0);
        oob_d    = sb_last_c.valid && sb_last_c.oob;
        drawx_d  = sb_last_c.drawx;
        drawy_d  = sb_last_c.drawy;
        chef_d   = sb_last_c.chef;
    end

    // Per-frame opaque pixel counter; frame_start has priority, saturating
    always_comb begin
        count_d = count_q;
        if (frame_start) begin
            count_d = '0;
        end else if (pix_valid_q && !transp_q && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            rom_rd_q    <= 1'b0;
            for (int i = 0; i <= int'(ROM_LAT); i++) begin
                sb_q[i] <= '0;
            end
            pix_valid_q <= 1'b0;
            cidx_q      <= '0;
            drawx_q     <= '0;
            drawy_q     <= '0;
            chef_q      <= 1'b0;
            transp_q    <= 1'b0;
            oob_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            rom_rd_q    <= rom_rd_d;
            for (int i = 0; i <= int'(ROM_LAT); i++) begin
                sb_q[i] <= sb_d[i];
            end
            pix_valid_q <= pix_valid_d;
            cidx_q      <= cidx_d;
            drawx_q     <= drawx_d;
            drawy_q     <= drawy_d;
            chef_q      <= chef_d;
            transp_q    <= transp_d;
            oob_q       <= oob_d;
            count_q     <= count_d;
        end
    end

    assign rom_addr           = rom_addr_q;
    assign rom_rd             = rom_rd_q;
    assign pix_valid          = pix_valid_q;
    assign sprite_color_index = cidx_q;
    assign pix_drawx          = drawx_q;
    assign pix_drawy          = drawy_q;
    assign pix_chef           = chef_q;
    assign pix_transparent    = transp_q;
    assign pix_oob            = oob_q;
    assign opaque_count       = count_q;

endmodule
